// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
//   Shared definitions for the oversampling UART receiver:
//     - parity mode constants (PAR_NONE / PAR_ODD / PAR_EVEN)
//     - receive FSM state encoding (rx_state_t)
//     - baud_div(): elaboration-time tick divisor, rounded to nearest
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_HIGH = 3'd5
    } rx_state_t;

    // Clock cycles per oversample tick: round(clk_hz / (baud * os)).
    // Clamped to 1 so the tick counter always has a legal terminal value.
    function automatic int baud_div(input longint clk_hz, input longint baud,
                                    input longint os);
        longint den;
        longint q;
        den = baud * os;
        q   = (clk_hz + den / 2) / den;
        if (q < 1) begin
            q = 1;
        end
        return int'(q);
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// ---------------------------------------------------------------------------
// uart_sync_fifo
//   Single-clock first-word-fall-through FIFO.
//   Ports:
//     clk, reset   : rising-edge clock, asynchronous active-low reset
//     push,wr_data : write request and word; dropped when full unless a
//                    pop happens in the same cycle
//     pop          : advance the head word; ignored while empty
//     rd_data      : head word, forced to 0 while empty
//     empty, full  : occupancy flags derived from count
//     count        : number of words held, 0..DEPTH
// ---------------------------------------------------------------------------
module uart_sync_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_FULL);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO
    // still lands.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    assign rd_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
//   Oversampling UART receiver (configurable data bits, parity, stop bits)
//   feeding a first-word-fall-through receive FIFO.
//   Ports:
//     clk, reset     : rising-edge clock, asynchronous active-low reset
//     RX             : asynchronous serial line, idles high
//     rd_en          : pop the head word (ignored while empty)
//     rd_data        : head data word
//     rd_frame_err   : head word had a stop bit sampled low
//     rd_parity_err  : head word failed parity (0 when parity is off)
//     empty/full     : FIFO occupancy flags
//     count          : words held
//     overrun        : sticky, a completed word was dropped on a full FIFO
//     clr_err        : pulse to clear overrun (a same-cycle overrun wins)
// ---------------------------------------------------------------------------
module uart_rx_fifo #(
    parameter int CLK_HZ     = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          RX,
    input  logic                          rd_en,
    output logic [DATA_BITS-1:0]          rd_data,
    output logic                          rd_frame_err,
    output logic                          rd_parity_err,
    output logic                          empty,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          overrun,
    input  logic                          clr_err
);

    import uart_pkg::*;

    localparam int DIV = baud_div(longint'(CLK_HZ), longint'(BAUD),
                                  longint'(OVERSAMPLE));
    localparam int TW  = $clog2(DIV + 1);
    localparam int SW  = $clog2(OVERSAMPLE);
    localparam int FW  = DATA_BITS + 2;

    localparam logic [TW-1:0] DIV_M1    = TW'(DIV - 1);
    localparam logic [TW-1:0] TICK_ONE  = TW'(1);
    localparam logic [SW-1:0] OS_M1     = SW'(OVERSAMPLE - 1);
    localparam logic [SW-1:0] SAMP_ONE  = SW'(1);
    // The vote fires on the tick that takes sample OS/2+1, when samples
    // OS/2-1 and OS/2 are already in the history register.
    localparam logic [SW-1:0] VOTE_IDX  = SW'(OVERSAMPLE / 2 + 1);
    localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

    function automatic logic majority3(input logic a, input logic b,
                                       input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Returns 1 when data plus parity bit violate the configured mode.
    function automatic logic parity_check(input logic [DATA_BITS-1:0] d,
                                          input logic p);
        logic ones_odd;
        ones_odd = ^{d, p};
        if (PARITY == PAR_ODD) begin
            return !ones_odd;
        end else if (PARITY == PAR_EVEN) begin
            return ones_odd;
        end
        return 1'b0;
    endfunction

    logic            rx_p0;
    logic            rx_p1;
    logic            vld_p0;
    logic            vld_p1;
    logic            rx_prev;
    logic            fall;

    logic [TW-1:0]   tick_cnt;
    logic            tick;
    logic [SW-1:0]   samp_cnt;
    logic [1:0]      hist;
    logic            vote;
    logic            bit_done;

    rx_state_t       state;
    logic [3:0]      bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic            frame_err_r;
    logic            par_err_r;
    logic            par_bit;

    logic            push;
    logic [FW-1:0]   push_word;
    logic [FW-1:0]   rd_word;
    logic            ovf_evt;

    // ---- stage p0/p1: line synchroniser ----
    // vld_pN marks when rx_pN carries a real line sample rather than the
    // reset value; rx_prev only arms edge detection once the line has
    // genuinely been seen high, so a line held low through reset release
    // cannot fake a start edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_p0   <= 1'b1;
            rx_p1   <= 1'b1;
            vld_p0  <= 1'b0;
            vld_p1  <= 1'b0;
            rx_prev <= 1'b0;
        end else begin
            rx_p0   <= RX;
            rx_p1   <= rx_p0;
            vld_p0  <= 1'b1;
            vld_p1  <= vld_p0;
            rx_prev <= rx_p1 & vld_p1;
        end
    end

    assign fall = vld_p1 && rx_prev && !rx_p1;

    // ---- oversample tick and sample counter ----
    assign tick     = (tick_cnt == DIV_M1);
    assign vote     = majority3(hist[1], hist[0], rx_p1);
    assign bit_done = tick && (samp_cnt == VOTE_IDX);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick_cnt <= '0;
            samp_cnt <= '0;
        end else if (state == IDLE && fall) begin
            tick_cnt <= '0;
            samp_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
            samp_cnt <= (samp_cnt == OS_M1) ? '0 : samp_cnt + SAMP_ONE;
        end else begin
            tick_cnt <= tick_cnt + TICK_ONE;
        end
    end

    // ---- receive FSM ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            bit_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    bit_cnt <= '0;
                    if (fall) begin
                        state <= START;
                    end
                end
                START: begin
                    if (bit_done) begin
                        state <= vote ? IDLE : DATA;
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        if (bit_cnt == DATA_LAST) begin
                            bit_cnt <= '0;
                            state   <= (PARITY != PAR_NONE) ? uart_pkg::PARITY : STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                end
                uart_pkg::PARITY: begin
                    if (bit_done) begin
                        state <= STOP;
                    end
                end
                STOP: begin
                    if (bit_done) begin
                        if (bit_cnt == STOP_LAST) begin
                            bit_cnt <= '0;
                            // A low line here is a break; hold off until
                            // it rises so it is not re-read as a start.
                            state   <= vote ? IDLE : WAIT_HIGH;
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                end
                WAIT_HIGH: begin
                    if (rx_p1) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // ---- shift register and per-word flags ----
    always_ff @(posedge clk) begin
        if (tick) begin
            hist <= {hist[0], rx_p1};
        end
        if (state == IDLE && fall) begin
            frame_err_r <= 1'b0;
        end
        if (bit_done) begin
            case (state)
                DATA:             shreg       <= {vote, shreg[DATA_BITS-1:1]};
                uart_pkg::PARITY: par_err_r   <= parity_check(shreg, vote);
                STOP:             if (!vote) frame_err_r <= 1'b1;
                default:          ;
            endcase
        end
    end

    assign par_bit   = (PARITY == PAR_NONE) ? 1'b0 : par_err_r;
    assign push      = (state == STOP) && bit_done && (bit_cnt == STOP_LAST);
    // The last stop bit's vote is folded in directly since frame_err_r
    // only updates on the same edge as the push.
    assign push_word = {par_bit, frame_err_r | !vote, shreg};

    // ---- receive FIFO ----
    uart_sync_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .wr_data (push_word),
        .pop     (rd_en),
        .rd_data (rd_word),
        .empty   (empty),
        .full    (full),
        .count   (count)
    );

    assign rd_data       = rd_word[DATA_BITS-1:0];
    assign rd_frame_err  = rd_word[DATA_BITS];
    assign rd_parity_err = rd_word[DATA_BITS+1];

    // ---- sticky overrun ----
    // full implies non-empty, so rd_en alone tells whether a pop frees a slot.
    assign ovf_evt = push && full && !rd_en;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overrun <= 1'b0;
        end else if (ovf_evt) begin
            overrun <= 1'b1;
        end else if (clr_err) begin
            overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_fifo
//   Directed bench for uart_rx_fifo. The line rate is scaled so one bit is
//   64 clocks (16 MHz / 250 kbaud, 16x oversampling, divisor 4), keeping
//   every scenario short. dut0 is 8N1, dut1 is 8E1.
// ---------------------------------------------------------------------------
module tb_uart_rx_fifo;
    import uart_pkg::*;

    localparam int CLK_HZ  = 16_000_000;
    localparam int BAUD    = 250_000;
    localparam int BIT_CYC = 64;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx0 = 1'b1;
    logic       rx1 = 1'b1;
    logic       rd_en0 = 1'b0;
    logic       rd_en1 = 1'b0;
    logic       clr0 = 1'b0;
    logic       clr1 = 1'b0;

    logic [7:0] rd_data0, rd_data1;
    logic       fe0, fe1, pe0, pe1;
    logic       empty0, empty1, full0, full1;
    logic [4:0] count0, count1;
    logic       ovr0, ovr1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_rx_fifo #(
        .CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(0),
        .STOP_BITS(1), .OVERSAMPLE(16), .FIFO_DEPTH(16)
    ) dut0 (
        .clk(clk), .reset(rst_n), .RX(rx0), .rd_en(rd_en0),
        .rd_data(rd_data0), .rd_frame_err(fe0), .rd_parity_err(pe0),
        .empty(empty0), .full(full0), .count(count0), .overrun(ovr0),
        .clr_err(clr0)
    );

    uart_rx_fifo #(
        .CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(2),
        .STOP_BITS(1), .OVERSAMPLE(16), .FIFO_DEPTH(16)
    ) dut1 (
        .clk(clk), .reset(rst_n), .RX(rx1), .rd_en(rd_en1),
        .rd_data(rd_data1), .rd_frame_err(fe1), .rd_parity_err(pe1),
        .empty(empty1), .full(full1), .count(count1), .overrun(ovr1),
        .clr_err(clr1)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_rx(input bit sel, input logic b);
        if (sel) rx1 = b;
        else     rx0 = b;
    endtask

    task automatic hold_bits(input int n);
        repeat (n * BIT_CYC) @(posedge clk);
    endtask

    task automatic send_frame(input bit sel, input logic [7:0] d,
                              input bit use_par, input logic par,
                              input logic stop);
        set_rx(sel, 1'b0);
        hold_bits(1);
        for (int i = 0; i < 8; i++) begin
            set_rx(sel, d[i]);
            hold_bits(1);
        end
        if (use_par) begin
            set_rx(sel, par);
            hold_bits(1);
        end
        set_rx(sel, stop);
        hold_bits(1);
        set_rx(sel, 1'b1);
    endtask

    task automatic pop(input bit sel);
        @(negedge clk);
        if (sel) rd_en1 = 1'b1;
        else     rd_en0 = 1'b1;
        @(negedge clk);
        rd_en0 = 1'b0;
        rd_en1 = 1'b0;
    endtask

    task automatic settle();
        repeat (4) @(negedge clk);
    endtask

    initial begin
        #600_000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset values
        repeat (3) @(negedge clk);
        check("rst_rd_data", 32'(rd_data0), 32'h0);
        check("rst_frame_err", 32'(fe0), 32'h0);
        check("rst_parity_err", 32'(pe0), 32'h0);
        check("rst_empty", 32'(empty0), 32'h1);
        check("rst_full", 32'(full0), 32'h0);
        check("rst_count", 32'(count0), 32'h0);
        check("rst_overrun", 32'(ovr0), 32'h0);
        check("rst_state", 32'(dut0.state), 32'(IDLE));
        rst_n = 1'b1;
        hold_bits(1);

        // Back-to-back 0x32, 0x31
        send_frame(1'b0, 8'h32, 1'b0, 1'b0, 1'b1);
        send_frame(1'b0, 8'h31, 1'b0, 1'b0, 1'b1);
        settle();
        check("b2b_count", 32'(count0), 32'd2);
        check("b2b_word0", 32'(rd_data0), 32'h32);
        check("b2b_fe0", 32'(fe0), 32'h0);
        check("b2b_pe0", 32'(pe0), 32'h0);
        pop(1'b0);
        check("b2b_word1", 32'(rd_data0), 32'h31);
        check("b2b_count_dec", 32'(count0), 32'd1);
        check("b2b_fe1", 32'(fe0), 32'h0);
        pop(1'b0);
        check("b2b_empty", 32'(empty0), 32'h1);

        // Start glitch of 12 clocks, well under half a bit
        @(posedge clk);
        rx0 = 1'b0;
        repeat (12) @(posedge clk);
        rx0 = 1'b1;
        hold_bits(2);
        settle();
        check("glitch_empty", 32'(empty0), 32'h1);
        check("glitch_state", 32'(dut0.state), 32'(IDLE));
        send_frame(1'b0, 8'h33, 1'b0, 1'b0, 1'b1);
        settle();
        check("glitch_next_count", 32'(count0), 32'd1);
        check("glitch_next_word", 32'(rd_data0), 32'h33);
        pop(1'b0);

        // Stop bit low followed by a long break
        send_frame(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        rx0 = 1'b0;
        hold_bits(29);
        settle();
        check("brk_count", 32'(count0), 32'd1);
        check("brk_word", 32'(rd_data0), 32'h00);
        check("brk_frame_err", 32'(fe0), 32'h1);
        check("brk_state", 32'(dut0.state), 32'(WAIT_HIGH));
        rx0 = 1'b1;
        hold_bits(1);
        settle();
        check("brk_release_state", 32'(dut0.state), 32'(IDLE));
        check("brk_release_count", 32'(count0), 32'd1);
        pop(1'b0);
        check("brk_empty", 32'(empty0), 32'h1);

        // Even parity: 0x35 has four ones, parity bit 0 is correct
        send_frame(1'b1, 8'h35, 1'b1, 1'b0, 1'b1);
        send_frame(1'b1, 8'h35, 1'b1, 1'b1, 1'b1);
        settle();
        check("par_count", 32'(count1), 32'd2);
        check("par_ok_word", 32'(rd_data1), 32'h35);
        check("par_ok_err", 32'(pe1), 32'h0);
        pop(1'b1);
        check("par_bad_word", 32'(rd_data1), 32'h35);
        check("par_bad_err", 32'(pe1), 32'h1);
        check("par_bad_fe", 32'(fe1), 32'h0);
        pop(1'b1);
        check("par_empty", 32'(empty1), 32'h1);

        // Overrun: 17 words into a 16-deep FIFO with no reads
        for (int i = 0; i < 17; i++) begin
            send_frame(1'b0, 8'(i), 1'b0, 1'b0, 1'b1);
            if (i == 15) begin
                settle();
                check("ovr_full_at16", 32'(full0), 32'h1);
                check("ovr_clear_at16", 32'(ovr0), 32'h0);
            end
        end
        settle();
        check("ovr_full", 32'(full0), 32'h1);
        check("ovr_count", 32'(count0), 32'd16);
        check("ovr_flag", 32'(ovr0), 32'h1);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("ovr_pop%0d", i), 32'(rd_data0), 32'(i));
            pop(1'b0);
        end
        check("ovr_drained", 32'(empty0), 32'h1);
        check("ovr_sticky", 32'(ovr0), 32'h1);
        @(negedge clk);
        clr0 = 1'b1;
        @(negedge clk);
        clr0 = 1'b0;
        check("ovr_cleared", 32'(ovr0), 32'h0);

        // Reset during data bit 4 of 0x0F; line stays low after release
        rx0 = 1'b0;
        hold_bits(1);
        for (int i = 0; i < 4; i++) begin
            rx0 = 1'b1;
            hold_bits(1);
        end
        rx0 = 1'b0;
        repeat (BIT_CYC / 2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (BIT_CYC / 2) @(posedge clk);
        hold_bits(3);
        rx0 = 1'b1;
        hold_bits(3);
        settle();
        check("rmf_empty", 32'(empty0), 32'h1);
        check("rmf_state", 32'(dut0.state), 32'(IDLE));
        send_frame(1'b0, 8'h41, 1'b0, 1'b0, 1'b1);
        settle();
        check("rmf_count", 32'(count0), 32'd1);
        check("rmf_word", 32'(rd_data0), 32'h41);
        check("rmf_fe", 32'(fe0), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
